// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operations,
// datapath mux selects and the data-processing cmd field values.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] SRCA_REG = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the saved {N,Z,C,V} flags.
module cond_check (
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condEx
);

   logic n, z, c, v;

   assign {n, z, c, v} = flags;

   // Decode the 4-bit condition field; the reserved 1111 encoding never executes
   always_comb begin
      condEx = 1'b0;
      case (cond)
         4'b0000: condEx = z;
         4'b0001: condEx = ~z;
         4'b0010: condEx = c;
         4'b0011: condEx = ~c;
         4'b0100: condEx = n;
         4'b0101: condEx = ~n;
         4'b0110: condEx = v;
         4'b0111: condEx = ~v;
         4'b1000: condEx = c & ~z;
         4'b1001: condEx = ~c | z;
         4'b1010: condEx = (n == v);
         4'b1011: condEx = (n != v);
         4'b1100: condEx = ~z & (n == v);
         4'b1101: condEx = z | (n != v);
         4'b1110: condEx = 1'b1;
         default: condEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM-subset core: main FSM, instruction
// decoder, flags register and the latched condition result that gates writes.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        Instr,
   input  logic [3:0]         ALUFlags,
   output logic               PCWrite,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic [1:0]         RegSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         ALUControl,
   output logic [STATE_W-1:0] State
);

   state_t      state, nextState;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  cmd;
   logic        rdIsPc;
   logic [3:0]  flags;
   logic        condEx, condExR;
   logic [1:0]  aluCmd;
   logic        cmdKnown, writesReg, updatesCv;
   logic        pcWriteRaw, memWriteRaw, regWriteRaw, irWriteRaw;
   logic        unusedInstrBits;

   assign op     = Instr[27:26];
   assign funct  = Instr[25:20];
   assign cmd    = funct[4:1];
   assign rdIsPc = (Instr[15:12] == 4'hF);
   assign ImmSrc = op;
   assign State  = STATE_W'(state);
   assign unusedInstrBits = ^{Instr[19:16], Instr[11:0]};

   cond_check uCondCheck (
      .cond   (Instr[31:28]),
      .flags  (flags),
      .condEx (condEx)
   );

   // Data-processing decode: ALU operation plus which side effects the cmd may have
   always_comb begin
      aluCmd    = ALU_ADD;
      cmdKnown  = 1'b0;
      writesReg = 1'b0;
      updatesCv = 1'b0;
      case (cmd)
         CMD_ADD: begin aluCmd = ALU_ADD; cmdKnown = 1'b1; writesReg = 1'b1; updatesCv = 1'b1; end
         CMD_SUB: begin aluCmd = ALU_SUB; cmdKnown = 1'b1; writesReg = 1'b1; updatesCv = 1'b1; end
         CMD_AND: begin aluCmd = ALU_AND; cmdKnown = 1'b1; writesReg = 1'b1; end
         CMD_ORR: begin aluCmd = ALU_ORR; cmdKnown = 1'b1; writesReg = 1'b1; end
         CMD_CMP: begin aluCmd = ALU_SUB; cmdKnown = 1'b1; updatesCv = 1'b1; end
         default: ;
      endcase
   end

   // State register; any reset restarts the instruction at FETCH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= nextState;
   end

   // Condition result is frozen on leaving DECODE so the instruction's own flag update cannot change its gating
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         condExR <= 1'b0;
         flags   <= 4'b0000;
      end else begin
         if (state == DECODE) condExR <= condEx;
         if ((state == EXECR || state == EXECI) && condExR && funct[0] && cmdKnown) begin
            flags[3:2] <= ALUFlags[3:2];
            if (updatesCv) flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Next-state and per-state datapath controls; strobes here are later masked by reset
   always_comb begin
      nextState   = FETCH;
      pcWriteRaw  = 1'b0;
      memWriteRaw = 1'b0;
      regWriteRaw = 1'b0;
      irWriteRaw  = 1'b0;
      AdrSrc      = 1'b0;
      RegSrc      = 2'b00;
      ALUSrcA     = SRCA_REG;
      ALUSrcB     = SRCB_WD;
      ResultSrc   = RES_ALUOUT;
      ALUControl  = ALU_ADD;
      case (state)
         FETCH: begin
            nextState  = DECODE;
            irWriteRaw = 1'b1;
            pcWriteRaw = 1'b1;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
         end
         DECODE: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            RegSrc    = {op == OP_MEM, op == OP_BR};
            case (op)
               OP_MEM:  nextState = MEMADR;
               OP_DP:   nextState = funct[5] ? EXECI : EXECR;
               OP_BR:   nextState = BRANCH;
               default: nextState = FETCH;
            endcase
         end
         MEMADR: begin
            nextState  = funct[0] ? MEMREAD : MEMWRITE;
            ALUSrcB    = SRCB_IMM;
            RegSrc[1]  = (op == OP_MEM);
         end
         MEMREAD: begin
            nextState = MEMWB;
            AdrSrc    = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc      = 1'b1;
            memWriteRaw = condExR;
         end
         MEMWB: begin
            ResultSrc   = RES_DATA;
            regWriteRaw = condExR & ~rdIsPc;
            pcWriteRaw  = condExR & rdIsPc;
         end
         EXECR: begin
            nextState  = ALUWB;
            ALUControl = aluCmd;
         end
         EXECI: begin
            nextState  = ALUWB;
            ALUSrcB    = SRCB_IMM;
            ALUControl = aluCmd;
         end
         ALUWB: begin
            regWriteRaw = condExR & writesReg & ~rdIsPc;
            pcWriteRaw  = condExR & writesReg & rdIsPc;
         end
         BRANCH: begin
            ALUSrcB    = SRCB_IMM;
            ResultSrc  = RES_ALURESULT;
            RegSrc     = 2'b01;
            pcWriteRaw = condExR;
         end
         default: nextState = FETCH;
      endcase
   end

   assign PCWrite  = pcWriteRaw  & reset;
   assign MemWrite = memWriteRaw & reset;
   assign RegWrite = regWriteRaw & reset;
   assign IRWrite  = irWriteRaw  & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions with
// literal expectations, then random instructions against an instruction-level model.
module tb_multicycle_controller;

   typedef struct packed {
      logic       pcW;
      logic       memW;
      logic       regW;
      logic       irW;
      logic       adrSrc;
      logic [1:0] regSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic [1:0] immSrc;
      logic [1:0] aluControl;
   } outs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
   logic [3:0]  State;

   outs_t       actual;
   outs_t       expOut;
   int          expState;
   bit          expValid = 1'b0;
   outs_t       seen [16];
   logic [31:0] trace = '0;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  mFlags;
   bit          mCondExR;

   localparam logic [31:0] I_ADD   = 32'hE2810005;
   localparam logic [31:0] I_LDR   = 32'hE5912004;
   localparam logic [31:0] I_STR   = 32'hE5812004;
   localparam logic [31:0] I_SUBS  = 32'hE0510002;
   localparam logic [31:0] I_BEQ   = 32'h0A000002;
   localparam logic [31:0] I_CMP   = 32'hE1500001;
   localparam logic [31:0] I_ADDPC = 32'hE281F005;
   localparam logic [31:0] I_OP11  = 32'hEC000000;

   always #5 clk = ~clk;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .RegSrc     (RegSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .State      (State)
   );

   assign actual = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   // ARM conditions come in complementary pairs: cond[3:1] picks the test, cond[0] inverts it
   function automatic bit condHolds(logic [3:0] cond, logic [3:0] f);
      bit n, z, c, v, base;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ cond[0];
   endfunction

   function automatic bit isKnown(logic [3:0] cmd);
      return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 ||
             cmd == 4'b1100 || cmd == 4'b1010;
   endfunction

   function automatic logic [1:0] aluFor(logic [3:0] cmd);
      if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
      if (cmd == 4'b0000) return 2'b10;
      if (cmd == 4'b1100) return 2'b11;
      return 2'b00;
   endfunction

   // Expected controls for one step of an instruction, given its latched condition result
   function automatic outs_t modelOut(int st, logic [31:0] ins, bit cx);
      outs_t      o;
      logic [1:0] op;
      logic [3:0] cmd;
      bit         rdPc, w;
      o    = '0;
      op   = ins[27:26];
      cmd  = ins[24:21];
      rdPc = (ins[15:12] == 4'hF);
      o.immSrc = op;
      case (st)
         0: begin o.irW = 1; o.pcW = 1; o.aluSrcA = 2'b01; o.aluSrcB = 2'b10; o.resultSrc = 2'b10; end
         1: begin
            o.aluSrcA = 2'b01; o.aluSrcB = 2'b10; o.resultSrc = 2'b10;
            o.regSrc = {op == 2'b01, op == 2'b10};
         end
         2: begin o.aluSrcB = 2'b01; o.regSrc = 2'b10; end
         3: o.adrSrc = 1;
         4: begin o.resultSrc = 2'b01; o.regW = cx && !rdPc; o.pcW = cx && rdPc; end
         5: begin o.adrSrc = 1; o.memW = cx; end
         6: o.aluControl = aluFor(cmd);
         7: begin o.aluSrcB = 2'b01; o.aluControl = aluFor(cmd); end
         8: begin
            w = cx && isKnown(cmd) && cmd != 4'b1010;
            o.regW = w && !rdPc;
            o.pcW  = w && rdPc;
         end
         9: begin o.aluSrcB = 2'b01; o.resultSrc = 2'b10; o.regSrc = 2'b01; o.pcW = cx; end
         default: o = '0;
      endcase
      return o;
   endfunction

   // Literal comparison used for the hand-computed expectations
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Drive one instruction through its step list (optionally stopping early) while advancing the model
   task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] af, input int stopAt);
      int         seq[$];
      logic [3:0] cmd;
      cmd = ins[24:21];
      seq = {0, 1};
      case (ins[27:26])
         2'b01: begin
            seq.push_back(2);
            if (ins[20]) begin seq.push_back(3); seq.push_back(4); end
            else seq.push_back(5);
         end
         2'b00: begin seq.push_back(ins[25] ? 7 : 6); seq.push_back(8); end
         2'b10: seq.push_back(9);
         default: ;
      endcase
      Instr    = ins;
      ALUFlags = af;
      for (int i = 0; i < seq.size(); i++) begin
         if (stopAt >= 0 && i >= stopAt) break;
         expOut   = modelOut(seq[i], ins, mCondExR);
         expState = seq[i];
         expValid = 1'b1;
         if (seq[i] == 1) mCondExR = condHolds(ins[31:28], mFlags);
         if ((seq[i] == 6 || seq[i] == 7) && mCondExR && ins[20] && isKnown(cmd)) begin
            mFlags[3:2] = af[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mFlags[1:0] = af[1:0];
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (expValid) begin
         checks++;
         if (State !== expState[3:0]) begin
            errors++;
            $display("[TB] FAIL state: got %0d expected %0d (Instr %h)", State, expState, Instr);
         end
         checks++;
         if (actual !== expOut) begin
            errors++;
            $display("[TB] FAIL controls in state %0d: got %h expected %h (Instr %h)",
                     expState, actual, expOut, Instr);
         end
         seen[State] = actual;
         trace = {trace[27:0], State};
      end
   end

   initial begin
      logic [31:0] ins;
      reset    = 1'b0;
      Instr    = '0;
      ALUFlags = '0;
      mFlags   = '0;
      mCondExR = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetState", 32'(State), 32'd0);
      checkOutput("resetPCWrite", 32'(PCWrite), 32'd0);
      checkOutput("resetIRWrite", 32'(IRWrite), 32'd0);
      reset = 1'b1;

      applyStimulus(I_ADD, 4'b0000, -1);
      checkOutput("addTrace", 32'(trace[15:0]), 32'h0178);
      checkOutput("addRegWrite", 32'(seen[8].regW), 32'd1);
      checkOutput("addResultSrc", 32'(seen[8].resultSrc), 32'd0);
      checkOutput("addAluControl", 32'(seen[8].aluControl), 32'd0);

      applyStimulus(I_LDR, 4'b0000, -1);
      checkOutput("ldrTrace", 32'(trace[19:0]), 32'h01234);
      checkOutput("ldrRegWrite", 32'(seen[4].regW), 32'd1);
      checkOutput("ldrResultSrc", 32'(seen[4].resultSrc), 32'd1);

      applyStimulus(I_STR, 4'b0000, -1);
      checkOutput("strTrace", 32'(trace[15:0]), 32'h0125);
      checkOutput("strMemWrite", 32'(seen[5].memW), 32'd1);
      checkOutput("strAdrSrc", 32'(seen[5].adrSrc), 32'd1);

      applyStimulus(I_SUBS, 4'b0100, -1);
      applyStimulus(I_BEQ, 4'b0000, -1);
      checkOutput("beqTakenTrace", 32'(trace[11:0]), 32'h019);
      checkOutput("beqTakenPCWrite", 32'(seen[9].pcW), 32'd1);

      applyStimulus(I_SUBS, 4'b0000, -1);
      applyStimulus(I_BEQ, 4'b0100, -1);
      checkOutput("beqNotTakenPCWrite", 32'(seen[9].pcW), 32'd0);

      applyStimulus(I_CMP, 4'b0100, -1);
      checkOutput("cmpRegWrite", 32'(seen[8].regW), 32'd0);
      checkOutput("cmpPCWrite", 32'(seen[8].pcW), 32'd0);
      applyStimulus(I_BEQ, 4'b0000, -1);
      checkOutput("cmpThenBeqPCWrite", 32'(seen[9].pcW), 32'd1);

      applyStimulus(I_ADDPC, 4'b0000, -1);
      checkOutput("rd15PCWrite", 32'(seen[8].pcW), 32'd1);
      checkOutput("rd15RegWrite", 32'(seen[8].regW), 32'd0);

      applyStimulus(I_OP11, 4'b0000, -1);
      checkOutput("op11Trace", 32'(trace[11:0]), 32'h801);

      applyStimulus(I_LDR, 4'b0000, 4);
      expValid = 1'b0;
      #1;
      checkOutput("memwbRegWriteBeforeReset", 32'(RegWrite), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midResetRegWrite", 32'(RegWrite), 32'd0);
      checkOutput("midResetPCWrite", 32'(PCWrite), 32'd0);
      checkOutput("midResetMemWrite", 32'(MemWrite), 32'd0);
      checkOutput("midResetState", 32'(State), 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      mFlags   = '0;
      mCondExR = 1'b0;
      applyStimulus(I_BEQ, 4'b0000, -1);
      checkOutput("flagsClearedBeq", 32'(seen[9].pcW), 32'd0);

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         if (ins[27:26] == 2'b00 && !isKnown(ins[24:21])) ins[20] = 1'b0;
         if ($urandom_range(3) == 0) ins[15:12] = 4'hF;
         if ($urandom_range(3) == 0) ins[31:28] = 4'hE;
         applyStimulus(ins, 4'($urandom_range(15)), -1);
      end

      expValid = 1'b0;
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
